rf_wb_arbiter: RTL and testbench

RF_WB_ARBITER -- requirements
Module: rf_wb_arbiter

---
 rtl/rf_wb_arbiter.sv | 108 ++++++++++
 tb/tb_rf_wb_arbiter.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: register-file scoreboard plus a two-port (EXU/LSU) writeback
// arbiter. Tracks busy destination registers to stall RAW/WAW hazards at issue,
// round-robins contended writebacks and registers the winning write.
module rf_wb_arbiter #(
    parameter int DATA_WIDTH   = 32,
    parameter int REG_OP_WIDTH = 5
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    issue_valid,
    input  logic [REG_OP_WIDTH-1:0] issue_rs1,
    input  logic [REG_OP_WIDTH-1:0] issue_rs2,
    input  logic [REG_OP_WIDTH-1:0] issue_rd,
    input  logic                    issue_wen,
    output logic                    issue_stall,
    input  logic                    exu_valid,
    input  logic                    lsu_valid,
    input  logic [REG_OP_WIDTH-1:0] exu_rd,
    input  logic [REG_OP_WIDTH-1:0] lsu_rd,
    input  logic [DATA_WIDTH-1:0]   exu_data,
    input  logic [DATA_WIDTH-1:0]   lsu_data,
    output logic                    exu_ready,
    output logic                    lsu_ready,
    output logic                    rf_wen,
    output logic [REG_OP_WIDTH-1:0] rf_rd,
    output logic [DATA_WIDTH-1:0]   rf_wdata,
    output logic [5:0]              pending_cnt,
    output logic                    err_spurious
);
    localparam int NREGS = 1 << REG_OP_WIDTH;

    logic [NREGS-1:0]        r_busy;
    logic [NREGS-1:0]        w_busy_nxt;
    logic [5:0]              r_cnt;
    logic [5:0]              w_cnt_nxt;
    logic                    r_ptr;       // 0 = EXU has priority, 1 = LSU
    logic                    r_wen;
    logic [REG_OP_WIDTH-1:0] r_rd;
    logic [DATA_WIDTH-1:0]   r_wdata;
    logic                    r_err;
    logic                    w_issue_fire;
    logic                    w_exu_gnt;
    logic                    w_lsu_gnt;
    logic                    w_xfer;
    logic [REG_OP_WIDTH-1:0] w_wb_rd;
    logic [DATA_WIDTH-1:0]   w_wb_data;

    // Hazard check against the scoreboard; busy[0] is never set so x0 never stalls.
    assign issue_stall  = issue_valid & (r_busy[issue_rs1] | r_busy[issue_rs2] |
                                         (issue_wen & r_busy[issue_rd]));
    assign w_issue_fire = issue_valid & ~issue_stall & ~reset;

    // Grants depend only on the valids, the pointer and reset (no ready loops).
    assign w_exu_gnt = ~reset & exu_valid & (~lsu_valid | ~r_ptr);
    assign w_lsu_gnt = ~reset & lsu_valid & (~exu_valid |  r_ptr);
    assign w_xfer    = w_exu_gnt | w_lsu_gnt;
    assign w_wb_rd   = w_exu_gnt ? exu_rd   : lsu_rd;
    assign w_wb_data = w_exu_gnt ? exu_data : lsu_data;

    assign exu_ready    = w_exu_gnt;
    assign lsu_ready    = w_lsu_gnt;
    assign rf_wen       = r_wen;
    assign rf_rd        = r_rd;
    assign rf_wdata     = r_wdata;
    assign pending_cnt  = r_cnt;
    assign err_spurious = r_err;

    // Next scoreboard: clear the register being written now, then apply the
    // issue set so a same-index set wins; popcount follows from the result.
    always_comb begin
        w_busy_nxt = r_busy;
        if (r_wen)
            w_busy_nxt[r_rd] = 1'b0;
        if (w_issue_fire && issue_wen && (issue_rd != '0))
            w_busy_nxt[issue_rd] = 1'b1;
        w_busy_nxt[0] = 1'b0;
        w_cnt_nxt = '0;
        for (int i = 0; i < NREGS; i++)
            w_cnt_nxt = w_cnt_nxt + {5'b0, w_busy_nxt[i]};
    end

    // Scoreboard, arbitration pointer, registered write and sticky error.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_busy  <= '0;
            r_cnt   <= '0;
            r_ptr   <= 1'b0;
            r_wen   <= 1'b0;
            r_rd    <= '0;
            r_wdata <= '0;
            r_err   <= 1'b0;
        end else begin
            r_busy <= w_busy_nxt;
            r_cnt  <= w_cnt_nxt;
            if (exu_valid && lsu_valid)
                r_ptr <= ~r_ptr;
            // rd=0 transfers are accepted but never reach the register file.
            r_wen <= w_xfer & (w_wb_rd != '0);
            if (w_xfer) begin
                r_rd    <= w_wb_rd;
                r_wdata <= w_wb_data;
            end
            // A write to a register nobody is waiting on points at a lost issue.
            if (r_wen && !r_busy[r_rd])
                r_err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Self-checking bench for rf_wb_arbiter: directed scenarios plus a randomized
// run against a behavioural scoreboard/arbiter model.
module tb_rf_wb_arbiter;
    logic        clock = 1'b0;
    logic        reset;
    logic        issue_valid, issue_wen;
    logic [4:0]  issue_rs1, issue_rs2, issue_rd;
    logic        issue_stall;
    logic        exu_valid, lsu_valid;
    logic [4:0]  exu_rd, lsu_rd;
    logic [31:0] exu_data, lsu_data;
    logic        exu_ready, lsu_ready;
    logic        rf_wen;
    logic [4:0]  rf_rd;
    logic [31:0] rf_wdata;
    logic [5:0]  pending_cnt;
    logic        err_spurious;

    int checks = 0;
    int errors = 0;

    rf_wb_arbiter #(.DATA_WIDTH(32), .REG_OP_WIDTH(5)) dut (
        .clock(clock), .reset(reset),
        .issue_valid(issue_valid), .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
        .issue_rd(issue_rd), .issue_wen(issue_wen), .issue_stall(issue_stall),
        .exu_valid(exu_valid), .lsu_valid(lsu_valid), .exu_rd(exu_rd), .lsu_rd(lsu_rd),
        .exu_data(exu_data), .lsu_data(lsu_data), .exu_ready(exu_ready), .lsu_ready(lsu_ready),
        .rf_wen(rf_wen), .rf_rd(rf_rd), .rf_wdata(rf_wdata),
        .pending_cnt(pending_cnt), .err_spurious(err_spurious)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        issue_valid = 0; issue_wen = 0; issue_rs1 = 0; issue_rs2 = 0; issue_rd = 0;
        exu_valid = 0; lsu_valid = 0; exu_rd = 0; lsu_rd = 0; exu_data = 0; lsu_data = 0;
    endtask

    task automatic do_reset();
        idle();
        reset = 1;
        tick();
        tick();
        reset = 0;
    endtask

    task automatic issue(input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [4:0] rd, input logic wen);
        issue_valid = 1; issue_rs1 = rs1; issue_rs2 = rs2; issue_rd = rd; issue_wen = wen;
    endtask

    task automatic test_reset();
        idle();
        reset = 1;
        exu_valid = 1; lsu_valid = 1; exu_rd = 3; lsu_rd = 4;
        issue(0, 0, 6, 1);
        tick();
        #1;
        checks++; if (exu_ready !== 1'b0) begin errors++; $display("FAIL reset_exu_ready got %0b want 0", exu_ready); end
        checks++; if (lsu_ready !== 1'b0) begin errors++; $display("FAIL reset_lsu_ready got %0b want 0", lsu_ready); end
        tick();
        reset = 0;
        idle();
        issue(6, 6, 6, 1);
        #1;
        checks++; if (pending_cnt !== 6'd0) begin errors++; $display("FAIL reset_pending got %0d want 0", pending_cnt); end
        checks++; if (rf_wen !== 1'b0) begin errors++; $display("FAIL reset_rf_wen got %0b want 0", rf_wen); end
        checks++; if (rf_rd !== 5'd0) begin errors++; $display("FAIL reset_rf_rd got %0d want 0", rf_rd); end
        checks++; if (rf_wdata !== 32'd0) begin errors++; $display("FAIL reset_rf_wdata got %h want 0", rf_wdata); end
        checks++; if (err_spurious !== 1'b0) begin errors++; $display("FAIL reset_err got %0b want 0", err_spurious); end
        checks++; if (issue_stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %0b want 0 (no issue during reset)", issue_stall); end
        idle();
    endtask

    task automatic test_raw_hazard();
        do_reset();
        issue(0, 0, 5, 1);
        #1;
        checks++; if (issue_stall !== 1'b0) begin errors++; $display("FAIL raw_first_stall got %0b want 0", issue_stall); end
        tick();
        checks++; if (pending_cnt !== 6'd1) begin errors++; $display("FAIL raw_pending_set got %0d want 1", pending_cnt); end
        issue(5, 0, 0, 0);
        #1;
        checks++; if (issue_stall !== 1'b1) begin errors++; $display("FAIL raw_stall got %0b want 1", issue_stall); end
        issue_valid = 0;
        exu_valid = 1; exu_rd = 5; exu_data = 32'hDEADBEEF;
        #1;
        checks++; if (exu_ready !== 1'b1) begin errors++; $display("FAIL raw_exu_ready got %0b want 1", exu_ready); end
        tick();
        exu_valid = 0;
        issue(5, 0, 0, 0);
        #1;
        checks++; if (rf_wen !== 1'b1 || rf_rd !== 5'd5 || rf_wdata !== 32'hDEADBEEF) begin
            errors++; $display("FAIL raw_write got wen=%0b rd=%0d data=%h want 1/5/deadbeef", rf_wen, rf_rd, rf_wdata); end
        checks++; if (issue_stall !== 1'b1) begin errors++; $display("FAIL raw_stall_during_write got %0b want 1", issue_stall); end
        tick();
        checks++; if (issue_stall !== 1'b0) begin errors++; $display("FAIL raw_stall_drop got %0b want 0", issue_stall); end
        checks++; if (pending_cnt !== 6'd0) begin errors++; $display("FAIL raw_pending_clear got %0d want 0", pending_cnt); end
        checks++; if (rf_wen !== 1'b0) begin errors++; $display("FAIL raw_wen_drop got %0b want 0", rf_wen); end
        checks++; if (err_spurious !== 1'b0) begin errors++; $display("FAIL raw_err got %0b want 0", err_spurious); end
        idle();
    endtask

    task automatic test_contention();
        do_reset();
        exu_valid = 1; lsu_valid = 1; exu_rd = 3; lsu_rd = 4;
        exu_data = 32'h0000_E0E0; lsu_data = 32'h0000_4040;
        for (int k = 0; k < 4; k++) begin
            #1;
            checks++; if (exu_ready !== (k % 2 == 0) || lsu_ready !== (k % 2 == 1)) begin
                errors++; $display("FAIL rr_grant%0d got exu=%0b lsu=%0b want exu=%0b", k, exu_ready, lsu_ready, (k % 2 == 0)); end
            tick();
            checks++; if (rf_wen !== 1'b1 || rf_rd !== ((k % 2 == 0) ? 5'd3 : 5'd4) ||
                          rf_wdata !== ((k % 2 == 0) ? 32'h0000_E0E0 : 32'h0000_4040)) begin
                errors++; $display("FAIL rr_write%0d got wen=%0b rd=%0d data=%h", k, rf_wen, rf_rd, rf_wdata); end
        end
        idle();
        tick();
        checks++; if (rf_wen !== 1'b0) begin errors++; $display("FAIL rr_idle_wen got %0b want 0", rf_wen); end
    endtask

    task automatic test_rd0();
        do_reset();
        issue(0, 0, 0, 1);
        #1;
        checks++; if (issue_stall !== 1'b0) begin errors++; $display("FAIL rd0_stall got %0b want 0", issue_stall); end
        tick();
        checks++; if (pending_cnt !== 6'd0) begin errors++; $display("FAIL rd0_pending got %0d want 0", pending_cnt); end
        idle();
        lsu_valid = 1; lsu_rd = 0; lsu_data = 32'h55;
        #1;
        checks++; if (lsu_ready !== 1'b1) begin errors++; $display("FAIL rd0_lsu_ready got %0b want 1", lsu_ready); end
        tick();
        idle();
        checks++; if (rf_wen !== 1'b0) begin errors++; $display("FAIL rd0_rf_wen got %0b want 0", rf_wen); end
        tick();
        checks++; if (err_spurious !== 1'b0) begin errors++; $display("FAIL rd0_err got %0b want 0", err_spurious); end
    endtask

    task automatic test_spurious();
        do_reset();
        exu_valid = 1; exu_rd = 7; exu_data = 32'h77;
        tick();
        idle();
        checks++; if (rf_wen !== 1'b1 || rf_rd !== 5'd7) begin errors++; $display("FAIL spur_write got wen=%0b rd=%0d want 1/7", rf_wen, rf_rd); end
        checks++; if (err_spurious !== 1'b0) begin errors++; $display("FAIL spur_early got %0b want 0", err_spurious); end
        tick();
        checks++; if (err_spurious !== 1'b1) begin errors++; $display("FAIL spur_set got %0b want 1", err_spurious); end
        for (int k = 0; k < 5; k++) tick();
        checks++; if (err_spurious !== 1'b1) begin errors++; $display("FAIL spur_sticky got %0b want 1", err_spurious); end
        do_reset();
        checks++; if (err_spurious !== 1'b0) begin errors++; $display("FAIL spur_reset got %0b want 0", err_spurious); end
    endtask

    task automatic test_set_clear();
        // busy[9] is idle, a write to 9 is registered and an issue to 9 fires in
        // the same cycle: the set must survive the clear.
        do_reset();
        exu_valid = 1; exu_rd = 9; exu_data = 32'h99;
        tick();
        idle();
        issue(0, 0, 9, 1);
        #1;
        checks++; if (rf_wen !== 1'b1 || rf_rd !== 5'd9 || issue_stall !== 1'b0) begin
            errors++; $display("FAIL sc_setup got wen=%0b rd=%0d stall=%0b want 1/9/0", rf_wen, rf_rd, issue_stall); end
        tick();
        issue(9, 0, 0, 0);
        #1;
        checks++; if (pending_cnt !== 6'd1) begin errors++; $display("FAIL sc_pending got %0d want 1", pending_cnt); end
        checks++; if (issue_stall !== 1'b1) begin errors++; $display("FAIL sc_busy9 stall got %0b want 1", issue_stall); end
        tick();
        checks++; if (pending_cnt !== 6'd1) begin errors++; $display("FAIL sc_pending_hold got %0d want 1", pending_cnt); end
        idle();
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int r = 1; r <= 3; r++) begin
            issue(0, 0, r[4:0], 1);
            tick();
        end
        idle();
        checks++; if (pending_cnt !== 6'd3) begin errors++; $display("FAIL mid_pending got %0d want 3", pending_cnt); end
        exu_valid = 1; exu_rd = 1; exu_data = 32'h11;
        tick();
        idle();
        checks++; if (rf_wen !== 1'b1) begin errors++; $display("FAIL mid_inflight got %0b want 1", rf_wen); end
        reset = 1;
        tick();
        reset = 0;
        issue(2, 3, 1, 1);
        #1;
        checks++; if (pending_cnt !== 6'd0) begin errors++; $display("FAIL mid_pending_rst got %0d want 0", pending_cnt); end
        checks++; if (rf_wen !== 1'b0) begin errors++; $display("FAIL mid_wen_rst got %0b want 0", rf_wen); end
        checks++; if (issue_stall !== 1'b0) begin errors++; $display("FAIL mid_stall_rst got %0b want 0", issue_stall); end
        idle();
    endtask

    task automatic test_random();
        bit          mb[32];
        bit          m_ptr, m_wen, m_err, e_hold, l_hold;
        bit          eg, lg, exp_stall, fire;
        logic [4:0]  m_rd;
        logic [31:0] m_data;
        int          cnt;
        do_reset();
        foreach (mb[i]) mb[i] = 0;
        m_ptr = 0; m_wen = 0; m_err = 0; e_hold = 0; l_hold = 0; m_rd = 0; m_data = 0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            if ($urandom_range(0, 99) == 0) begin
                idle();
                reset = 1;
                #1;
                checks++; if (exu_ready !== 1'b0 || lsu_ready !== 1'b0) begin
                    errors++; $display("FAIL rnd_rst_ready cyc%0d got %0b/%0b want 0/0", cyc, exu_ready, lsu_ready); end
                tick();
                reset = 0;
                foreach (mb[i]) mb[i] = 0;
                m_ptr = 0; m_wen = 0; m_err = 0; e_hold = 0; l_hold = 0; m_rd = 0; m_data = 0;
                continue;
            end
            issue_valid = $urandom_range(0, 1);
            issue_wen   = $urandom_range(0, 1);
            issue_rs1   = 5'($urandom_range(0, 7));
            issue_rs2   = 5'($urandom_range(0, 7));
            issue_rd    = 5'($urandom_range(0, 7));
            if (!e_hold) begin
                exu_valid = $urandom_range(0, 1);
                exu_rd = 5'($urandom_range(0, 7)); exu_data = $urandom;
            end
            if (!l_hold) begin
                lsu_valid = $urandom_range(0, 1);
                lsu_rd = 5'($urandom_range(0, 7)); lsu_data = $urandom;
            end
            // Expected handshake from the model.
            exp_stall = issue_valid && (mb[issue_rs1] || mb[issue_rs2] || (issue_wen && mb[issue_rd]));
            if (exu_valid && lsu_valid) begin eg = !m_ptr; lg = m_ptr; end
            else begin eg = exu_valid; lg = lsu_valid; end
            #1;
            checks++; if (issue_stall !== exp_stall) begin errors++; $display("FAIL rnd_stall cyc%0d got %0b want %0b", cyc, issue_stall, exp_stall); end
            checks++; if (exu_ready !== eg || lsu_ready !== lg) begin
                errors++; $display("FAIL rnd_grant cyc%0d got %0b/%0b want %0b/%0b", cyc, exu_ready, lsu_ready, eg, lg); end
            // Advance the model across the edge.
            fire = issue_valid && !exp_stall;
            if (m_wen) begin
                if (!mb[m_rd]) m_err = 1;
                mb[m_rd] = 0;
            end
            if (fire && issue_wen && issue_rd != 0) mb[issue_rd] = 1;
            if (exu_valid && lsu_valid) m_ptr = !m_ptr;
            m_wen = 0;
            if (eg) begin m_wen = (exu_rd != 0); m_rd = exu_rd; m_data = exu_data; end
            if (lg) begin m_wen = (lsu_rd != 0); m_rd = lsu_rd; m_data = lsu_data; end
            e_hold = exu_valid && !eg;
            l_hold = lsu_valid && !lg;
            tick();
            cnt = 0;
            foreach (mb[i]) cnt += mb[i];
            checks++; if (rf_wen !== m_wen) begin errors++; $display("FAIL rnd_wen cyc%0d got %0b want %0b", cyc, rf_wen, m_wen); end
            if (m_wen) begin
                checks++; if (rf_rd !== m_rd || rf_wdata !== m_data) begin
                    errors++; $display("FAIL rnd_wdata cyc%0d got %0d/%h want %0d/%h", cyc, rf_rd, rf_wdata, m_rd, m_data); end
            end
            checks++; if (pending_cnt !== 6'(cnt)) begin errors++; $display("FAIL rnd_pending cyc%0d got %0d want %0d", cyc, pending_cnt, cnt); end
            checks++; if (err_spurious !== m_err) begin errors++; $display("FAIL rnd_err cyc%0d got %0b want %0b", cyc, err_spurious, m_err); end
        end
        idle();
    endtask

    initial begin
        reset = 1;
        idle();
        test_reset();
        test_raw_hazard();
        test_contention();
        test_rd0();
        test_spurious();
        test_set_clear();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
